// File: rtl/mc_mem_unit.sv
// Unified instruction/data memory with IR and MDR for a multicycle CPU; single-cycle access by default.
// Define MC_MEM_WAIT_EN for wait-state operation (WAIT_CYCLES+1 edges per access, mem_ready low while busy).
module mc_mem_unit #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic [31:0] ALUOut,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] Instr,
  output logic [6:0]  Opcode,
  output logic [31:0] MDR,
  output logic        mem_ready,
  output logic        mem_done,
  output logic        misalign_err,
  output logic        collide_err
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   instr_q, mdr_q;
  logic          done_q, misalign_q, collide_q;
  logic [31:0]   addr;
  logic          req;
  logic          commit;
  logic [AW-1:0] c_idx;
  logic [31:0]   c_wd;
  logic          c_rd, c_wr, c_irw;

  assign addr = IorD ? ALUOut : PC;
  assign req  = (MemRead | MemWrite) & mem_ready;

`ifdef MC_MEM_WAIT_EN
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   wd_q;
  logic          rd_q, wr_q, irw_q;

  assign mem_ready = (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wd_q    <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      irw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Snapshot the request so inputs may change freely while waiting.
      if (req) begin
        idx_q <= addr[AW+1:2];
        wd_q  <= WriteData;
        rd_q  <= MemRead;
        wr_q  <= MemWrite;
        irw_q <= IRWrite;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign c_idx = idx_q;
  assign c_wd  = wd_q;
  assign c_rd  = rd_q;
  assign c_wr  = wr_q;
  assign c_irw = irw_q;
`else
  assign mem_ready = 1'b1;
  assign commit    = req;
  assign c_idx     = addr[AW+1:2];
  assign c_wd      = WriteData;
  assign c_rd      = MemRead;
  assign c_wr      = MemWrite;
  assign c_irw     = IRWrite;
`endif

  // Array has no reset; rst only blocks a write committing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_wr)
      mem_q[c_idx] <= c_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= 32'd0;
      mdr_q      <= 32'd0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      done_q <= commit;
      // A write wins over a simultaneous read.
      if (commit && c_rd && !c_wr) begin
        mdr_q <= mem_q[c_idx];
        if (c_irw)
          instr_q <= mem_q[c_idx];
      end
      if (req && (addr[1:0] != 2'b00))
        misalign_q <= 1'b1;
      if (req && MemRead && MemWrite)
        collide_q <= 1'b1;
    end
  end

  assign Instr        = instr_q;
  assign Opcode       = instr_q[6:0];
  assign MDR          = mdr_q;
  assign mem_done     = done_q;
  assign misalign_err = misalign_q;
  assign collide_err  = collide_q;
endmodule
